// File: rtl/framebuffer_writer_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_writer_pkg
// Shared raster types and constants for the framebuffer write path.
//   - Tile geometry used to derive the default screen size.
//   - Fixed-point coordinate format: signed Q(FX_INT_BITS.FX_FRAC_BITS).
//   - coord_2d_t  : (x, y) pixel position as delivered by the pixel processor.
//   - fb_entry_t  : {addr, color} write-buffer entry for the default screen.
//   - fb_state_t  : retire FSM states.
//   - fx_to_int() : fixed-point to integer pixel index (fraction truncated).
// -----------------------------------------------------------------------------
package framebuffer_writer_pkg;

    localparam int TILE_COLUMNS = 8;
    localparam int TILE_ROWS    = 8;
    localparam int TILE_WIDTH   = 8;
    localparam int TILE_HEIGHT  = 8;

    localparam int COLOR_BITS   = 8;
    localparam int FX_INT_BITS  = 8;
    localparam int FX_FRAC_BITS = 4;
    localparam int FX_BITS      = FX_INT_BITS + FX_FRAC_BITS;

    localparam int DEF_SCREEN_W  = TILE_COLUMNS * TILE_WIDTH;
    localparam int DEF_SCREEN_H  = TILE_ROWS * TILE_HEIGHT;
    localparam int DEF_ADDR_BITS = $clog2(DEF_SCREEN_W * DEF_SCREEN_H);

    typedef logic signed [FX_BITS-1:0] fx_t;

    typedef struct packed {
        fx_t x;
        fx_t y;
    } coord_2d_t;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [COLOR_BITS-1:0]    color;
    } fb_entry_t;

    typedef enum logic {
        FB_IDLE,
        FB_DRAIN
    } fb_state_t;

    // Arithmetic shift: negative coordinates round toward minus infinity.
    function automatic fx_t fx_to_int(input fx_t v);
        return v >>> FX_FRAC_BITS;
    endfunction

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// -----------------------------------------------------------------------------
// fb_write_fifo
// Synchronous write-buffer FIFO with occupancy count. The head entry is
// presented combinationally; a pop advances it on the next edge.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   i_push       : write i_data at the tail
//   i_data       : entry to store
//   i_pop        : remove the head entry (ignored when empty)
//   o_head       : current head entry
//   o_count      : number of stored entries (0..DEPTH)
//   o_empty      : no entries stored
// Parameters: DEPTH (power of two, >= 4), T_ENTRY (entry type).
// -----------------------------------------------------------------------------
module fb_write_fifo
    import framebuffer_writer_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type T_ENTRY = fb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  T_ENTRY                 i_data,
    input  logic                   i_pop,
    output T_ENTRY                 o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T_ENTRY          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & ~w_full;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The upstream ready threshold guarantees the buffer can never overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/framebuffer_writer.sv
// -----------------------------------------------------------------------------
// framebuffer_writer
// Receives (x, y, colour) pixel beats, converts the fixed-point position to a
// linear framebuffer word address, buffers in-range pixels in fb_write_fifo
// and retires them through a req/gnt write port. Retired and dropped pixels
// are counted; frame_done pulses when a full screen has been accounted for.
// Optional build macro:
//   FB_SKIP_ZERO_EN : colour-0 beats are not written but still counted.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pix_vld     : beat valid (always accepted)
//   pix_color   : beat colour
//   pix_coord   : beat position, signed fixed point per axis
//   pix_rdy     : producer may issue a beat next cycle
//   mem_req     : write request (FIFO not empty)
//   mem_addr    : write word address (FIFO head)
//   mem_data    : write data (FIFO head)
//   mem_gnt     : write accepted this cycle
//   frame_done  : one-cycle pulse when the frame count wraps
//   err_oob     : sticky, an out-of-screen pixel was dropped
// -----------------------------------------------------------------------------
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_vld,
    input  logic [COLOR_BITS-1:0] pix_color,
    input  coord_2d_t             pix_coord,
    output logic                  pix_rdy,
    output logic                  mem_req,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [COLOR_BITS-1:0] mem_data,
    input  logic                  mem_gnt,
    output logic                  frame_done,
    output logic                  err_oob
);

    localparam int FRAME_PIX = SCREEN_W * SCREEN_H;
    localparam int CNT_W     = $clog2(FRAME_PIX + 2);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] FRAME_LIMIT = CNT_W'(FRAME_PIX);
    localparam logic [CW:0]      RDY_LIMIT   = (CW+1)'(FIFO_DEPTH - 2);

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [COLOR_BITS-1:0] color;
    } entry_t;

    // ---------------- address stage (combinational, before S1) -------------
    fx_t                  w_xs;
    fx_t                  w_ys;
    logic signed [31:0]   w_xi;
    logic signed [31:0]   w_yi;
    logic [ADDR_BITS:0]   w_addr;
    logic                 w_oob;
    logic                 w_skip;

    assign w_xs   = fx_to_int(pix_coord.x);
    assign w_ys   = fx_to_int(pix_coord.y);
    assign w_xi   = {{(32-FX_BITS){w_xs[FX_BITS-1]}}, w_xs};
    assign w_yi   = {{(32-FX_BITS){w_ys[FX_BITS-1]}}, w_ys};
    assign w_addr = (ADDR_BITS+1)'(w_yi * SCREEN_W + w_xi);
    // The extra address bit can only be set for an out-of-screen position.
    assign w_oob  = (w_xi < 0) | (w_xi >= SCREEN_W) |
                    (w_yi < 0) | (w_yi >= SCREEN_H) | w_addr[ADDR_BITS];

`ifdef FB_SKIP_ZERO_EN
    assign w_skip = (pix_color == '0);
`else
    assign w_skip = 1'b0;
`endif

    // ---------------- S1 input register ------------------------------------
    logic   r_s1_vld;
    logic   r_s1_oob;
    logic   r_s1_skip;
    entry_t r_s1_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_s1_skip  <= 1'b0;
            r_s1_entry <= '0;
        end else begin
            r_s1_vld <= pix_vld;
            if (pix_vld) begin
                r_s1_oob         <= w_oob;
                r_s1_skip        <= w_skip;
                r_s1_entry.addr  <= w_addr[ADDR_BITS-1:0];
                r_s1_entry.color <= pix_color;
            end
        end
    end

    logic w_push;
    logic w_drop;
    logic w_pop;

    assign w_push = r_s1_vld & ~r_s1_oob & ~r_s1_skip;
    assign w_drop = r_s1_vld & (r_s1_oob | r_s1_skip);
    assign w_pop  = mem_req & mem_gnt;

    // ---------------- write buffer -----------------------------------------
    entry_t        w_head;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_empty;

    fb_write_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .T_ENTRY (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (r_s1_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Counting the in-flight S1 beat leaves one slot of skid for the beat the
    // producer issues after sampling ready.
    logic [CW:0] w_occ;
    assign w_occ   = {1'b0, w_fifo_count} + (CW+1)'(r_s1_vld);
    assign pix_rdy = (w_occ <= RDY_LIMIT);

    // ---------------- retire FSM -------------------------------------------
    fb_state_t r_state;
    fb_state_t w_state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FB_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FB_IDLE:  if (w_push) w_state_next = FB_DRAIN;
            FB_DRAIN: if (w_pop && !w_push && (w_fifo_count == CW'(1)))
                          w_state_next = FB_IDLE;
            default:  w_state_next = FB_IDLE;
        endcase
    end

    assign mem_req  = (r_state == FB_DRAIN);
    assign mem_addr = mem_req ? w_head.addr  : '0;
    assign mem_data = mem_req ? w_head.color : '0;

    a_req_tracks_fifo: assert property (@(posedge clk) disable iff (!rst_n) mem_req == !w_fifo_empty);

    // ---------------- frame counter ----------------------------------------
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;

    // A pop and a drop in the same cycle add 2; crossing the limit wraps to
    // the remainder with a single pulse.
    assign w_cnt_sum  = r_frame_cnt + CNT_W'(w_pop) + CNT_W'(w_drop);
    assign frame_done = (w_cnt_sum >= FRAME_LIMIT);
    assign w_cnt_next = frame_done ? (w_cnt_sum - FRAME_LIMIT) : w_cnt_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_frame_cnt <= '0;
        else        r_frame_cnt <= w_cnt_next;
    end

    // ---------------- sticky out-of-screen flag ----------------------------
    logic r_err_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_err_oob <= 1'b0;
        else if (r_s1_vld && r_s1_oob)  r_err_oob <= 1'b1;
    end

    assign err_oob = r_err_oob;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;
    import framebuffer_writer_pkg::*;

    localparam int SW = 64;
    localparam int SH = 64;
    localparam int NPIX = SW * SH;
`ifdef FB_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
    localparam int FRAME_ZEROS = 4000;
`else
    localparam bit SKIP_ZERO = 1'b0;
    localparam int FRAME_ZEROS = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  pix_vld;
    logic [COLOR_BITS-1:0] pix_color;
    coord_2d_t             pix_coord;
    logic                  pix_rdy;
    logic                  mem_req;
    logic [11:0]           mem_addr;
    logic [COLOR_BITS-1:0] mem_data;
    logic                  mem_gnt;
    logic                  frame_done;
    logic                  err_oob;

    framebuffer_writer #(
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .FIFO_DEPTH (4),
        .ADDR_BITS  (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_vld    (pix_vld),
        .pix_color  (pix_color),
        .pix_coord  (pix_coord),
        .pix_rdy    (pix_rdy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_gnt    (mem_gnt),
        .frame_done (frame_done),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int color; } wr_t;

    wr_t exp_q[$];
    int  drop_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  beats_sent = 0;
    int  writes_seen = 0;
    int  act_frames = 0;
    int  exp_frames = 0;
    int  exp_cnt = 0;
    int  gnt_mode = 0;
    bit  exp_oob = 1'b0;
    bit  rdy_s = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor division by 16 of a fixed-point value held in 1/16 units.
    function automatic int fx_floor(input int v);
        if (v >= 0) return v / 16;
        return -((-v + 15) / 16);
    endfunction

    always @(posedge clk) cyc++;
    always @(negedge clk) rdy_s = pix_rdy;

    initial begin
        mem_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       mem_gnt = 1'b0;
                1:       mem_gnt = 1'b1;
                default: mem_gnt = ($urandom_range(99) < 60);
            endcase
        end
    end

    // Monitor: retirements against the scoreboard, frame accounting per cycle.
    always @(negedge clk) begin : monitor
        int  ev;
        bit  exp_done;
        wr_t e;
        if (rst_n) begin
            ev = 0;
            while (drop_q.size() > 0 && drop_q[0] <= cyc) begin
                void'(drop_q.pop_front());
                ev++;
            end
            if (mem_req && mem_gnt) begin
                ev++;
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("stale_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_data, e.color);
                end
            end
            exp_cnt += ev;
            exp_done = 1'b0;
            if (exp_cnt >= NPIX) begin
                exp_done = 1'b1;
                exp_cnt -= NPIX;
                exp_frames++;
            end
            if (frame_done) act_frames++;
            if (frame_done || exp_done) check("frame_done", frame_done, exp_done);
        end
    end

    // Issue one beat, honouring the one-cycle-delayed ready protocol.
    task automatic send(input int x, input int y, input int c);
        int  guard = 0;
        int  xi = fx_floor(x);
        int  yi = fx_floor(y);
        wr_t e;
        while (!rdy_s) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                $display("FAIL send_timeout: got %0d expected %0d", 0, 1);
                $fatal(1, "producer stalled");
            end
        end
        pix_vld     = 1'b1;
        pix_coord.x = FX_BITS'(x);
        pix_coord.y = FX_BITS'(y);
        pix_color   = COLOR_BITS'(c);
        beats_sent++;
        if (xi < 0 || xi >= SW || yi < 0 || yi >= SH) begin
            exp_oob = 1'b1;
            drop_q.push_back(cyc + 1);
        end else if (SKIP_ZERO && c == 0) begin
            drop_q.push_back(cyc + 1);
        end else begin
            e.addr  = yi * SW + xi;
            e.color = c;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pix_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || drop_q.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size() + drop_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int order[NPIX];
    int base;
    int w0;
    int f0;
    int exp_writes;
    bit got;

    initial begin
        rst_n     = 1'b0;
        pix_vld   = 1'b0;
        pix_color = '0;
        pix_coord = '0;
        #2;
        check("rst_pix_rdy", pix_rdy, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_oob", err_oob, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel (5.0, 2.0), latency to the write port.
        gnt_mode = 1;
        @(posedge clk);
        #1;
        send(5 * 16, 2 * 16, 8'h03);
        @(negedge clk);
        check("lat_s1_no_req", mem_req, 0);
        @(negedge clk);
        check("lat_req", mem_req, 1);
        check("lat_addr", mem_addr, 133);
        check("lat_data", mem_data, 3);
        @(negedge clk);
        check("lat_retired", mem_req, 0);
        wait_drain("single_drain");
        check("single_err_oob", err_oob, 0);

        // Eight beats into a stalled port: ready falls with occupancy 3.
        gnt_mode = 0;
        @(posedge clk);
        #1;
        base = beats_sent;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i * 16 + i, 10 * 16 + 5, 8'h10 + i);
            end
            begin
                got = 1'b0;
                for (int k = 0; k < 60 && !got; k++) begin
                    @(negedge clk);
                    if (!pix_rdy) got = 1'b1;
                end
                check("stall_rdy_falls", got, 1);
                check("stall_beats_at_rdy_low", beats_sent - base, 4);
                repeat (4) @(negedge clk);
                check("stall_beats_held", beats_sent - base, 4);
                check("stall_req", mem_req, 1);
                check("stall_addr_held", mem_addr, 10 * SW);
                check("stall_rdy_low", pix_rdy, 0);
                gnt_mode = 1;
            end
        join
        wait_drain("stall_drain");

        // Out-of-screen positions and edge pixels.
        check("oob_pre", err_oob, 0);
        send(64 * 16, 0, 8'h21);
        send(-16, 3 * 16, 8'h22);
        send(-8, 16, 8'h23);
        send(0, 64 * 16, 8'h24);
        send(63 * 16 + 15, 63 * 16 + 15, 8'h5A);
        send(0, 0, 8'h77);
        wait_drain("oob_drain");
        check("oob_sticky", err_oob, 1);

        // Reset with three buffered pixels.
        gnt_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(20 + i * 16, 40 * 16, 8'h30 + i);
        repeat (3) @(negedge clk);
        check("prerst_req", mem_req, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        drop_q.delete();
        exp_cnt = 0;
        exp_oob = 1'b0;
        #1;
        check("midrst_req", mem_req, 0);
        check("midrst_rdy", pix_rdy, 1);
        check("midrst_addr", mem_addr, 0);
        check("midrst_err_oob", err_oob, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt_mode = 1;
        repeat (10) @(negedge clk);
        check("postrst_req", mem_req, 0);

        // Full frame, shuffled order, random grant stalls.
        for (int i = 0; i < NPIX; i++) order[i] = i;
        for (int i = NPIX - 1; i > 0; i--) begin
            int j = $urandom_range(i);
            int t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        gnt_mode = 2;
        @(posedge clk);
        #1;
        w0 = writes_seen;
        f0 = act_frames;
        exp_writes = 0;
        for (int i = 0; i < NPIX; i++) begin
            int c = (i < FRAME_ZEROS) ? 0 : $urandom_range(255, (SKIP_ZERO ? 1 : 0));
            if (!(SKIP_ZERO && c == 0)) exp_writes++;
            send((order[i] % SW) * 16 + $urandom_range(15),
                 (order[i] / SW) * 16 + $urandom_range(15), c);
        end
        wait_drain("frame_drain");
        check("frame_writes", writes_seen - w0, exp_writes);
        check("frame_pulses", act_frames - f0, 1);
        check("frame_err_oob", err_oob, 0);

        // Random mix of in-range and out-of-screen beats across a frame wrap.
        for (int i = 0; i < 4200; i++) begin
            if ($urandom_range(9) < 7)
                send($urandom_range(SW * 16 - 1), $urandom_range(SH * 16 - 1), $urandom_range(255));
            else
                send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
                     $urandom_range(255));
        end
        wait_drain("mix_drain");
        check("mix_frames", act_frames, exp_frames);
        check("mix_err_oob", err_oob, exp_oob);
        check("mix_idle_req", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
